// File: rtl/bp_me_pkg.sv
// Shared trace-capture types: channel index enum and the default-width trace record.
package bp_me_pkg;

  localparam int trace_chan_id_width_gp = 3;
  localparam int trace_type_width_gp    = 4;

  typedef enum logic [2:0] {
    e_trace_lce_req  = 3'd0,
    e_trace_lce_resp = 3'd1,
    e_trace_lce_cmd  = 3'd2,
    e_trace_mem_cmd  = 3'd3,
    e_trace_mem_resp = 3'd4
  } bp_me_trace_chan_e;

  // Record layout at the default 32-bit timestamp / 40-bit address widths.
  typedef struct packed {
    logic [31:0]       ts;
    bp_me_trace_chan_e chan_id;
    logic [3:0]        msg_type;
    logic [39:0]       addr;
  } bp_me_trace_rec_s;

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small first-word-fall-through FIFO; ready_o reflects only occupancy, so a full
// FIFO refuses enqueue even when the head is being dequeued in the same cycle.
module bsg_fifo_1r1w_small
  #(parameter int width_p = 8
    ,parameter int els_p  = 8
    )
  (input  logic               clk_i
   ,input  logic              reset_i
   ,input  logic              v_i
   ,output logic              ready_o
   ,input  logic [width_p-1:0] data_i
   ,output logic              v_o
   ,output logic [width_p-1:0] data_o
   ,input  logic              yumi_i
   );

  localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;

  logic [width_p-1:0]  mem_q [els_p];
  logic [ptr_w_lp-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [ptr_w_lp:0]   count_q, count_d;
  logic                enq, deq;

  assign ready_o = (count_q != (ptr_w_lp+1)'(els_p));
  assign v_o     = (count_q != '0);
  assign data_o  = mem_q[rptr_q];
  assign enq     = v_i & ready_o;
  assign deq     = yumi_i & v_o;

  always_comb begin
    wptr_d  = enq ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = deq ? rptr_q + 1'b1 : rptr_q;
    count_d = count_q;
    case ({enq, deq})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq)
      mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/bp_me_cce_trace_capture.sv
// Captures CCE header handshakes into one pending slot per channel, then moves slots
// round-robin into a record FIFO, stamping each with a free-running cycle counter.
module bp_me_cce_trace_capture
  import bp_me_pkg::*;
  #(parameter int num_chan_p     = 5
    ,parameter int paddr_width_p = 40
    ,parameter int ts_width_p    = 32
    ,parameter int fifo_els_p    = 8
    )
  (input  logic                                clk_i
   ,input  logic                               reset_i
   ,input  logic                               freeze_i
   ,input  logic [num_chan_p-1:0]              chan_v_i
   ,input  logic [4*num_chan_p-1:0]            chan_type_i
   ,input  logic [paddr_width_p*num_chan_p-1:0] chan_addr_i
   ,output logic [ts_width_p+trace_chan_id_width_gp+trace_type_width_gp+paddr_width_p-1:0] trace_o
   ,output logic                               trace_v_o
   ,input  logic                               trace_ready_and_i
   ,output logic [15:0]                        drop_count_o
   );

  localparam int rec_width_lp = ts_width_p + trace_chan_id_width_gp
                              + trace_type_width_gp + paddr_width_p;

  logic [ts_width_p-1:0]    ts_q, ts_d;
  logic [num_chan_p-1:0]    slot_v_q, slot_v_d, load, drop, grant;
  logic [ts_width_p-1:0]    slot_ts_q   [num_chan_p];
  logic [3:0]               slot_type_q [num_chan_p];
  logic [paddr_width_p-1:0] slot_addr_q [num_chan_p];
  logic [2:0]               rr_q, rr_d;
  logic [15:0]              drop_cnt_q, drop_cnt_d;
  logic [16:0]              drop_sum;
  logic                     fifo_ready, grant_v;
  logic [rec_width_lp-1:0]  enq_rec;
  logic [3:0]               arb_sum;
  logic [2:0]               arb_idx;

  assign ts_d = ts_q + 1'b1;

  // Search starts at rr_q and wraps; the first valid slot wins when the FIFO has room.
  always_comb begin
    grant   = '0;
    grant_v = 1'b0;
    enq_rec = '0;
    rr_d    = rr_q;
    arb_sum = '0;
    arb_idx = '0;
    for (int i = 0; i < num_chan_p; i++) begin
      arb_sum = {1'b0, rr_q} + 4'(i);
      if (arb_sum >= 4'(num_chan_p))
        arb_sum = arb_sum - 4'(num_chan_p);
      arb_idx = arb_sum[2:0];
      if (fifo_ready && !grant_v && slot_v_q[arb_idx]) begin
        grant_v          = 1'b1;
        grant[arb_idx]   = 1'b1;
        enq_rec          = {slot_ts_q[arb_idx], arb_idx, slot_type_q[arb_idx], slot_addr_q[arb_idx]};
        rr_d             = (arb_idx == 3'(num_chan_p-1)) ? 3'd0 : arb_idx + 3'd1;
      end
    end
  end

  // A granted slot may be reloaded in the same cycle; only an ungranted full slot drops.
  for (genvar gi = 0; gi < num_chan_p; gi++) begin : g_slot
    assign load[gi]     = chan_v_i[gi] & ~freeze_i & (~slot_v_q[gi] | grant[gi]);
    assign drop[gi]     = chan_v_i[gi] & ~freeze_i & slot_v_q[gi] & ~grant[gi];
    assign slot_v_d[gi] = load[gi] | (slot_v_q[gi] & ~grant[gi]);
  end

  always_ff @(posedge clk_i) begin
    for (int c = 0; c < num_chan_p; c++) begin
      if (load[c]) begin
        slot_ts_q[c]   <= ts_q;
        slot_type_q[c] <= chan_type_i[4*c +: 4];
        slot_addr_q[c] <= chan_addr_i[paddr_width_p*c +: paddr_width_p];
      end
    end
  end

  always_comb begin
    drop_sum = {1'b0, drop_cnt_q};
    for (int i = 0; i < num_chan_p; i++)
      drop_sum = drop_sum + 17'(drop[i]);
    drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ts_q       <= '0;
      slot_v_q   <= '0;
      rr_q       <= '0;
      drop_cnt_q <= '0;
    end else begin
      ts_q       <= ts_d;
      slot_v_q   <= slot_v_d;
      rr_q       <= rr_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_count_o = drop_cnt_q;

  bsg_fifo_1r1w_small
    #(.width_p (rec_width_lp)
      ,.els_p  (fifo_els_p)
      )
    trace_fifo
    (.clk_i    (clk_i)
     ,.reset_i (reset_i)
     ,.v_i     (grant_v)
     ,.ready_o (fifo_ready)
     ,.data_i  (enq_rec)
     ,.v_o     (trace_v_o)
     ,.data_o  (trace_o)
     ,.yumi_i  (trace_v_o & trace_ready_and_i)
     );

endmodule

// File: tb/tb_bp_me_cce_trace_capture.sv
// Randomized bench for bp_me_cce_trace_capture against a queue-based behavioural model.
module tb_bp_me_cce_trace_capture;
  import bp_me_pkg::*;

  localparam int N  = 5;
  localparam int AW = 40;
  localparam int TW = 32;
  localparam int FE = 8;
  localparam int RW = TW + 3 + 4 + AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset_i, freeze_i, trace_v_o, trace_ready_and_i;
  logic [N-1:0]    chan_v_i;
  logic [4*N-1:0]  chan_type_i;
  logic [AW*N-1:0] chan_addr_i;
  logic [RW-1:0]   trace_o;
  logic [15:0]     drop_count_o;

  bp_me_cce_trace_capture #(.num_chan_p(N), .paddr_width_p(AW), .ts_width_p(TW), .fifo_els_p(FE)) dut (
    .clk_i(clk), .reset_i(reset_i), .freeze_i(freeze_i), .chan_v_i(chan_v_i),
    .chan_type_i(chan_type_i), .chan_addr_i(chan_addr_i), .trace_o(trace_o),
    .trace_v_o(trace_v_o), .trace_ready_and_i(trace_ready_and_i), .drop_count_o(drop_count_o));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural model: per-channel pending records, an output queue, and counters.
  bit            m_v   [N];
  logic [RW-1:0] m_rec [N];
  logic [RW-1:0] m_q[$];
  logic [TW-1:0] m_ts;
  int            m_rr;
  int            m_drops;

  function automatic void model_edge();
    int win;
    int c;
    if (reset_i) begin
      for (int k = 0; k < N; k++) m_v[k] = 0;
      m_q.delete();
      m_ts = '0; m_rr = 0; m_drops = 0;
      return;
    end
    win = -1;
    if (m_q.size() < FE) begin
      for (int k = 0; k < N; k++) begin
        c = (m_rr + k) % N;
        if (win < 0 && m_v[c]) win = c;
      end
    end
    if (m_q.size() > 0 && trace_ready_and_i) void'(m_q.pop_front());
    if (win >= 0) begin
      m_q.push_back(m_rec[win]);
      m_v[win] = 0;
      m_rr = (win + 1) % N;
    end
    for (int k = 0; k < N; k++) begin
      if (chan_v_i[k] && !freeze_i) begin
        if (m_v[k]) begin
          if (m_drops < 65535) m_drops++;
        end else begin
          m_v[k]   = 1;
          m_rec[k] = {m_ts, 3'(k), chan_type_i[4*k +: 4], chan_addr_i[AW*k +: AW]};
        end
      end
    end
    m_ts = m_ts + 1'b1;
  endfunction

  int            dut_deq;
  logic [RW-1:0] seen[$];

  task automatic tick();
    if (!reset_i && trace_v_o && trace_ready_and_i) begin
      dut_deq++;
      seen.push_back(trace_o);
    end
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("trace_v", trace_v_o, m_q.size() > 0);
    if (m_q.size() > 0) chk("trace_rec", trace_o, m_q[0]);
    chk("drop_count", drop_count_o, m_drops);
  endtask

  task automatic idle();
    chan_v_i = '0;
  endtask

  task automatic fire(input int c, input logic [3:0] t, input logic [AW-1:0] a);
    chan_v_i[c]            = 1'b1;
    chan_type_i[4*c +: 4]  = t;
    chan_addr_i[AW*c +: AW] = a;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    freeze_i = 1'b0;
    idle();
    tick();
    reset_i = 1'b0;
    dut_deq = 0;
    seen.delete();
  endtask

  logic [RW-1:0]      exp_rec;
  bp_me_trace_rec_s   r;
  int                 drops_before;

  initial begin
    reset_i = 1'b1; freeze_i = 1'b0; trace_ready_and_i = 1'b1;
    chan_v_i = '0; chan_type_i = '0; chan_addr_i = '0;
    dut_deq = 0;
    @(negedge clk);
    do_reset();
    chk("rst_trace_v", trace_v_o, 1'b0);
    chk("rst_drop", drop_count_o, 16'd0);

    // Single lce_req event at ts 10 visible in cycle 12.
    repeat (10) tick();
    fire(0, 4'h1, 40'h80_0000_0040);
    tick();
    idle();
    tick();
    exp_rec = {32'd10, 3'd0, 4'h1, 40'h80_0000_0040};
    chk("single_v", trace_v_o, 1'b1);
    chk("single_rec", trace_o, exp_rec);
    repeat (3) tick();

    // All channels in one cycle leave in channel order.
    do_reset();
    repeat (20) tick();
    for (int c = 0; c < N; c++) fire(c, 4'(c + 3), AW'(c * 64 + 40'h1000));
    tick();
    idle();
    repeat (10) tick();
    chk("all_count", seen.size(), 5);
    for (int i = 0; i < 5 && i < seen.size(); i++) begin
      r = bp_me_trace_rec_s'(seen[i]);
      chk("all_chan", r.chan_id, i);
      chk("all_ts", r.ts, 20);
    end
    chk("all_drop", drop_count_o, 16'd0);

    // Channel 2 refires while lower-index slots hold arbitration priority.
    do_reset();
    fire(0, 4'h2, 40'h100); fire(1, 4'h3, 40'h200);
    tick();
    idle(); fire(2, 4'h4, 40'h300);
    tick();
    idle(); fire(2, 4'h5, 40'h340);
    tick();
    idle();
    chk("refire_drop", drop_count_o, 16'd1);
    repeat (6) tick();

    // Stalled consumer: 8 queued, slot held, 11 drops, then 9 drained.
    do_reset();
    trace_ready_and_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      idle(); fire(1, 4'($urandom_range(0, 15)), AW'({$urandom, $urandom}));
      tick();
    end
    idle();
    chk("stall_drop", drop_count_o, 16'd11);
    chk("stall_v", trace_v_o, 1'b1);
    trace_ready_and_i = 1'b1;
    repeat (15) tick();
    chk("stall_drained", dut_deq, 9);

    // Reset with queued records and drops pending.
    do_reset();
    trace_ready_and_i = 1'b0;
    for (int i = 0; i < 14; i++) begin
      idle(); fire(1, 4'h7, AW'(i));
      tick();
    end
    idle();
    chk("pre_rst_drop", drop_count_o, 16'd5);
    do_reset();
    chk("mid_rst_v", trace_v_o, 1'b0);
    chk("mid_rst_drop", drop_count_o, 16'd0);
    trace_ready_and_i = 1'b1;
    fire(0, 4'h9, 40'h55);
    tick();
    idle();
    tick();
    exp_rec = {32'd0, 3'd0, 4'h9, 40'h55};
    chk("post_rst_rec", trace_o, exp_rec);
    repeat (3) tick();

    // Freeze blocks capture and does not count drops.
    drops_before = drop_count_o;
    dut_deq = 0;
    freeze_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idle(); fire(3, 4'hA, AW'(i));
      tick();
    end
    idle(); freeze_i = 1'b0;
    repeat (4) tick();
    chk("freeze_recs", dut_deq, 0);
    chk("freeze_drop", drop_count_o, drops_before);

    // Randomized traffic with occasional freeze and reset.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      reset_i  = ($urandom_range(0, 299) == 0);
      freeze_i = ($urandom_range(0, 19) == 0);
      trace_ready_and_i = (cyc % 1000 < 500) ? ($urandom_range(0, 3) != 0)
                                              : ($urandom_range(0, 3) == 0);
      for (int c = 0; c < N; c++) begin
        chan_v_i[c]             = ($urandom_range(0, 2) == 0);
        chan_type_i[4*c +: 4]   = 4'($urandom_range(0, 15));
        chan_addr_i[AW*c +: AW] = AW'({$urandom, $urandom});
      end
      tick();
    end
    reset_i = 1'b0; freeze_i = 1'b0; idle();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
